uart_rx_deframer: RTL

//  Consumes bytes from the UART driver's receive side (rx_data/rx_valid) and extracts framed packets:

---
 rtl/uart_rx_deframer.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer
// Pulls framed packets (SYNC, LEN, payload, CSUM) out of the UART receive
// byte stream. Payload is held in a local buffer until the checksum has been
// verified, then drained over a ready/valid byte interface with a last flag.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_SYNC    | hunting for SYNC_BYTE, everything else ignored
// S_LEN     | next byte is the payload length
// S_PAYLOAD | storing payload bytes into the buffer, accumulating checksum
// S_CSUM    | next byte is the checksum, decides accept/discard
// S_DRAIN   | streaming the verified payload downstream, new bytes dropped
module uart_rx_deframer #(
  parameter int          CLK_HZ    = 12_500_000,
  parameter int          BAUDRATE  = 115200,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int          MAX_LEN   = 64,
  parameter int          TIMEOUT   = (CLK_HZ / BAUDRATE) * 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [15:0] drop_count
);

  // Length register must hold MAX_LEN itself; buffer index only needs 0..MAX_LEN-1.
  // MAX_LEN is assumed to fit in the 8-bit LEN field.
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT - 1);
  localparam logic [8:0]    MAX_LEN_V = 9'(MAX_LEN);

  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  typedef enum logic [2:0] {
    S_SYNC,
    S_LEN,
    S_PAYLOAD,
    S_CSUM,
    S_DRAIN
  } state_t;

  state_t          state_q;
  state_t          state_d;

  logic            rx_valid_q;
  logic            byte_stb;

  logic [LW-1:0]   len_q;
  logic [LW-1:0]   wr_ptr_q;
  logic [LW-1:0]   rd_ptr_q;
  logic [7:0]      acc_q;
  logic [7:0]      csum_sum;
  logic [TW-1:0]   tmo_cnt_q;
  logic [7:0]      buf_mem [MAX_LEN];

  logic            in_frame;
  logic            tmo_hit;
  logic            len_bad;
  logic            csum_good;
  logic            pay_done;
  logic            last_beat;
  logic            rd_hs;

  logic            ok_set;
  logic            err_set;
  logic [1:0]      err_val;

  // One byte per rising edge of the level-style rx_valid. The delayed copy
  // resets high so a valid already asserted at reset exit is not taken.
  assign byte_stb = rx_valid & ~rx_valid_q;

  assign in_frame  = (state_q == S_LEN) | (state_q == S_PAYLOAD) | (state_q == S_CSUM);
  assign tmo_hit   = in_frame & ~byte_stb & (tmo_cnt_q == '0);
  assign len_bad   = (rx_data == 8'd0) | ({1'b0, rx_data} > MAX_LEN_V);
  assign csum_sum  = acc_q + rx_data;
  assign csum_good = (csum_sum == 8'd0);
  assign pay_done  = (wr_ptr_q == len_q - LW'(1));
  assign last_beat = (rd_ptr_q == len_q - LW'(1));

  // The buffer read is combinational, so data and last follow rd_ptr directly
  // and stay put while the consumer stalls.
  assign m_valid = (state_q == S_DRAIN);
  assign m_last  = m_valid & last_beat;
  assign m_data  = m_valid ? buf_mem[rd_ptr_q[PW-1:0]] : 8'h00;
  assign rd_hs   = m_valid & m_ready;

  // Edge detector history for rx_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_valid_q <= 1'b1;
    end else begin
      rx_valid_q <= rx_valid;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode plus accept/discard decisions; timeout overrides the
  // per-state decode but never coincides with a byte strobe.
  always_comb begin
    state_d = state_q;
    ok_set  = 1'b0;
    err_set = 1'b0;
    err_val = ERR_LEN;
    case (state_q)
      S_SYNC: begin
        if (byte_stb && (rx_data == SYNC_BYTE)) begin
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (byte_stb) begin
          if (len_bad) begin
            err_set = 1'b1;
            err_val = ERR_LEN;
            state_d = S_SYNC;
          end else begin
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (byte_stb && pay_done) begin
          state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (byte_stb) begin
          if (csum_good) begin
            ok_set  = 1'b1;
            state_d = S_DRAIN;
          end else begin
            err_set = 1'b1;
            err_val = ERR_CSUM;
            state_d = S_SYNC;
          end
        end
      end
      S_DRAIN: begin
        if (rd_hs && last_beat) begin
          state_d = S_SYNC;
        end
      end
      default: begin
        state_d = S_SYNC;
      end
    endcase
    if (tmo_hit) begin
      err_set = 1'b1;
      err_val = ERR_TMO;
      state_d = S_SYNC;
    end
  end

  // Length, checksum accumulator and buffer pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q    <= '0;
      acc_q    <= 8'h00;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (byte_stb && (state_q == S_LEN)) begin
        len_q    <= rx_data[LW-1:0];
        acc_q    <= rx_data;
        wr_ptr_q <= '0;
      end
      if (byte_stb && (state_q == S_PAYLOAD)) begin
        acc_q    <= acc_q + rx_data;
        wr_ptr_q <= wr_ptr_q + LW'(1);
      end
      if (byte_stb && (state_q == S_CSUM)) begin
        rd_ptr_q <= '0;
      end
      if (rd_hs) begin
        rd_ptr_q <= rd_ptr_q + LW'(1);
      end
    end
  end

  // Payload storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (byte_stb && (state_q == S_PAYLOAD)) begin
      buf_mem[wr_ptr_q[PW-1:0]] <= rx_data;
    end
  end

  // Inter-byte timeout: down-counter reloaded on every byte and whenever no
  // frame is being assembled; terminal count at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q <= TMO_LOAD;
    end else if (byte_stb || !in_frame) begin
      tmo_cnt_q <= TMO_LOAD;
    end else if (tmo_cnt_q != '0) begin
      tmo_cnt_q <= tmo_cnt_q - TW'(1);
    end
  end

  // Status pulses, sticky error cause and saturating overrun counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= 2'd0;
      drop_count <= 16'h0000;
    end else begin
      frame_ok  <= ok_set;
      frame_err <= err_set;
      if (err_set) begin
        err_code <= err_val;
      end
      if (byte_stb && (state_q == S_DRAIN) && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

endmodule
